opb_hazard_ctrl: RTL and testbench
==================================

# opb_hazard_ctrl

Forwarding and load-use hazard controller for the ALU B-operand path. Sits at the ID/EX boundary: it tracks the destination registers of the two instructions ahead of decode, computes the B-mux select and the rt forwarding select, and registers both into the EX stage. It stalls decode on load-use hazards and counts stall cycles for performance monitoring.

## Interface
- `STALL_CNT_W`, default 16: width of the saturating stall counter.
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  a valid instruction is in ID.
- `id_rt`  in  5  rt source register of the ID instruction.
- `id_reads_rt`  in  1  the ID instruction consumes rt (ALU B operand or store data).
- `id_use_imm`  in  1  the ALU B operand is the immediate.
- `id_wr_en`, `id_rd`, `id_is_load`  in  1/5/1  destination info of the ID instruction.
- `flush`  in  1  squash the ID instruction (branch taken in EX).
- `stall`  out  1  hold PC and the IF/ID register; combinational.
- `ex_valid`  out  1  the EX-stage instruction is valid (not a bubble).
- `ex_mux_lines`  out  2  B-mux select. Bit1 = 1 selects immediate (B2); bit1 = 0 selects register (B1). Bit0 is always 0.
- `ex_fwd_sel`  out  2  rt source: 00 = regfile, 01 = EX/MEM result, 10 = MEM/WB result. Code 11 is never driven.
- `stall_cnt`  out  STALL_CNT_W  saturating count of stall cycles.

## Operation
- History registers:
  - EX entry {valid, wr_en, rd, is_load}, loaded from ID when the pipeline advances.
  - MEM entry, loaded from the EX entry every cycle.
- A match requires all of: the entry is valid, wr_en = 1, rd ≠ 0, and rd == `id_rt`.
- Hazard evaluation applies only when `id_valid & id_reads_rt`. Otherwise fwd = 00 and no stall.
- Load-use: an EX-entry match with is_load = 1 gives `stall` = 1.
  - The EX entry is replaced by a bubble (valid = 0).
  - The IF/ID stage holds, so the same ID instruction re-evaluates next cycle.
- Forwarding:
  - An EX-entry match (non-load) gives fwd = 01.
  - Else a MEM-entry match gives fwd = 10.
  - Else fwd = 00.
  - The younger entry (EX) has priority.
- `ex_mux_lines[1]` = registered `id_use_imm`, independent of forwarding.
- FSM states:
  - RUN: goes to STALL when stall = 1.
  - STALL: goes to RUN when stall = 0.
  - With forwarding compiled in, STALL lasts exactly 1 cycle; a second consecutive stall is a design error (flagged by assertion).
- `stall_cnt` increments on each cycle with stall = 1 and saturates at all-ones.
- `flush`:
  - The next EX entry is a bubble.
  - `stall` is forced to 0 and the FSM returns to RUN.
  - Flush wins over a simultaneous hazard.
  - The MEM entry is unaffected.

## Timing
- Reset (sync, `rst` = 1 at the edge) clears:
  - EX and MEM entries, so `ex_valid` = 0.
  - `ex_mux_lines` = 00, `ex_fwd_sel` = 00, `stall_cnt` = 0.
  - FSM to RUN.
- `stall` is also 0 during reset.
- Reset mid-stall discards the held hazard; no stall in the cycle after reset.
- Latency: selects computed in ID cycle N appear on `ex_*` in cycle N+1.
- Load-use sequence with forwarding:
  - ID evaluates in cycle N; stall = 1.
  - Bubble in EX in N+1; the load is now in MEM; fwd = 10 is decided.
  - The instruction is in EX in N+2.

## Configuration
- `OPB_HAZARD_FWD_EN` defined: forwarding as described.
- Not defined:
  - `ex_fwd_sel` is tied to 00.
  - Any EX- or MEM-entry match stalls, loads or not.
  - STALL may last up to 2 cycles; the bound assertion becomes 2.
  - The regfile is write-before-read, so WB needs no stall.

## Structure
- Shared package `opb_pkg`:
  - `fwd_sel_t` encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB).
  - `hist_entry_t` struct.
  - FSM state enum.
  - Constant REG_ZERO = 5'd0.
- One sub-module, `opb_hist_stage`: a single history entry register with bubble insertion, instantiated twice.

## Test plan
- EX holds addu rd = 5; ID reads rt = 5 → stall 0, next-cycle `ex_fwd_sel` = 01, `ex_mux_lines` = 00.
- EX holds lw rd = 7; ID reads rt = 7 → stall 1 for exactly 1 cycle, `ex_valid` = 0 next cycle, then `ex_fwd_sel` = 10, `stall_cnt` = 1.
- EX and MEM both write rd = 3; ID reads rt = 3 → fwd = 01; rd = 0 writer with rt = 0 → fwd = 00.
- lw hazard with `flush` = 1 in the same cycle → stall 0, `ex_valid` = 0, FSM stays RUN, `stall_cnt` unchanged.
- `id_use_imm` = 1, `id_reads_rt` = 0, matching EX writer → `ex_mux_lines` = 10, fwd = 00, no stall; `rst` asserted during a stall → all outputs 0 next cycle.
- Build without `OPB_HAZARD_FWD_EN`: EX addu rd = 4, ID reads rt = 4 → stall 2 cycles, `stall_cnt` = 2, `ex_fwd_sel` stays 00.

Source files
------------

// File: rtl/opb_pkg.sv
// opb_pkg: shared types for the ALU B-operand hazard controller.
//   fwd_sel_t    - rt forwarding source encodings
//   hist_entry_t - one pipeline history entry (EX or MEM)
//   state_t      - stall FSM states
//   REG_ZERO     - hard-wired zero register
//   hist_match() - true when an entry produces the register being read
package opb_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic       valid;
    logic       wr_en;
    logic [4:0] rd;
    logic       is_load;
  } hist_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  // Writes to r0 are discarded, so a producer of r0 never matches.
  function automatic logic hist_match(input hist_entry_t e, input logic [4:0] rt);
    return e.valid && e.wr_en && (e.rd != REG_ZERO) && (e.rd == rt);
  endfunction

endpackage

// File: rtl/opb_hist_stage.sv
// opb_hist_stage: one history entry register with bubble insertion.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   bubble_i  - load an empty entry instead of d_i
//   d_i       - entry to capture
//   q_o       - registered entry
module opb_hist_stage
  import opb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        bubble_i,
  input  hist_entry_t d_i,
  output hist_entry_t q_o
);

  hist_entry_t q_q;

  always_ff @(posedge clk) begin
    if (rst || bubble_i) q_q <= '0;
    else                 q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/opb_hazard_ctrl.sv
// opb_hazard_ctrl: forwarding / load-use hazard control for the ALU B operand.
// Tracks the two instructions ahead of decode (EX, MEM), stalls decode on
// hazards, and registers the B-mux and rt-forwarding selects into EX.
// Build option: OPB_HAZARD_FWD_EN enables forwarding; without it every
// EX/MEM producer match stalls and ex_fwd_sel stays 00.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   id_valid, id_rt,
//   id_reads_rt, id_use_imm  - operand info of the ID instruction
//   id_wr_en, id_rd,
//   id_is_load               - destination info of the ID instruction
//   flush                    - squash the ID instruction
//   stall                    - hold PC and IF/ID (combinational)
//   ex_valid, ex_mux_lines,
//   ex_fwd_sel               - registered EX-stage controls
//   stall_cnt                - saturating stall-cycle counter
module opb_hazard_ctrl
  import opb_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [4:0]             id_rt,
  input  logic                   id_reads_rt,
  input  logic                   id_use_imm,
  input  logic                   id_wr_en,
  input  logic [4:0]             id_rd,
  input  logic                   id_is_load,
  input  logic                   flush,
  output logic                   stall,
  output logic                   ex_valid,
  output logic [1:0]             ex_mux_lines,
  output logic [1:0]             ex_fwd_sel,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

`ifdef OPB_HAZARD_FWD_EN
  localparam int STALL_MAX = 1;
`else
  localparam int STALL_MAX = 2;
`endif

  hist_entry_t id_ent, ex_q, mem_q;
  logic        check, ex_hit, mem_hit, hazard, bubble;
  fwd_sel_t    fwd_d, fwd_q;
  logic        use_imm_q;
  state_t      state_q, state_d;
  logic [1:0]  run_q, run_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic        unused_mem_ld;

  assign unused_mem_ld = mem_q.is_load;

  assign check   = id_valid & id_reads_rt;
  assign ex_hit  = check & hist_match(ex_q, id_rt);
  assign mem_hit = check & hist_match(mem_q, id_rt);

`ifdef OPB_HAZARD_FWD_EN
  // Only a load still in EX is too late to forward; everything else bypasses.
  assign hazard = ex_hit & ex_q.is_load;

  // EX is the younger producer, so it wins over MEM.
  always_comb begin
    fwd_d = FWD_RF;
    if (ex_hit)       fwd_d = FWD_EXMEM;
    else if (mem_hit) fwd_d = FWD_MEMWB;
  end
`else
  assign hazard = ex_hit | mem_hit;
  assign fwd_d  = FWD_RF;
`endif

  // Flush squashes the ID instruction, so its hazard is moot.
  assign stall  = hazard & ~flush & ~rst;
  assign bubble = stall | flush;

  assign id_ent = '{valid: id_valid, wr_en: id_wr_en, rd: id_rd, is_load: id_is_load};

  opb_hist_stage u_ex (
    .clk      (clk),
    .rst      (rst),
    .bubble_i (bubble),
    .d_i      (id_ent),
    .q_o      (ex_q)
  );

  opb_hist_stage u_mem (
    .clk      (clk),
    .rst      (rst),
    .bubble_i (1'b0),
    .d_i      (ex_q),
    .q_o      (mem_q)
  );

  // A bubble carries all-zero controls.
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      use_imm_q <= 1'b0;
      fwd_q     <= FWD_RF;
    end else begin
      use_imm_q <= id_use_imm;
      fwd_q     <= fwd_d;
    end
  end

  // run_q counts consecutive stall cycles for the bound check.
  always_comb begin
    state_d = state_q;
    run_d   = 2'd0;
    case (state_q)
      ST_RUN: begin
        if (stall) begin
          state_d = ST_STALL;
          run_d   = 2'd1;
        end
      end
      ST_STALL: begin
        if (stall) run_d = (run_q == 2'd3) ? 2'd3 : run_q + 2'd1;
        else       state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign cnt_d = (stall && cnt_q != '1) ? cnt_q + STALL_CNT_W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      run_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
    end
  end

  a_stall_bound: assert property (@(posedge clk) disable iff (rst) run_q <= 2'(STALL_MAX));

  assign ex_valid     = ex_q.valid;
  assign ex_mux_lines = {use_imm_q, 1'b0};
  assign ex_fwd_sel   = fwd_q;
  assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_opb_hazard_ctrl.sv
// tb_opb_hazard_ctrl: directed vector table plus randomized stimulus checked
// against a behavioural model of the EX/MEM producer history.
module tb_opb_hazard_ctrl;

`ifdef OPB_HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int CW      = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, id_valid, id_reads_rt, id_use_imm, id_wr_en, id_is_load, flush;
  logic [4:0]    id_rt, id_rd;
  logic          stall, ex_valid;
  logic [1:0]    ex_mux_lines, ex_fwd_sel;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  opb_hazard_ctrl #(.STALL_CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rt        (id_rt),
    .id_reads_rt  (id_reads_rt),
    .id_use_imm   (id_use_imm),
    .id_wr_en     (id_wr_en),
    .id_rd        (id_rd),
    .id_is_load   (id_is_load),
    .flush        (flush),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .ex_mux_lines (ex_mux_lines),
    .ex_fwd_sel   (ex_fwd_sel),
    .stall_cnt    (stall_cnt)
  );

  typedef struct {
    bit rst, v; int rt; bit rdrt, imm, wr; int rd; bit ld, fl;
    bit e_stall, e_valid; int e_mux, e_fwd, e_cnt;
  } vec_t;

  typedef struct { bit v, w; int rd; bit ld; } ent_t;

  int   n_pass = 0, n_total = 0;
  vec_t tbl[$];

  // Model: the two older instructions, newest first.
  ent_t m_ex, m_mem;
  int   m_cnt = 0, m_valid = 0, m_mux = 0, m_fwd = 0;

  function automatic vec_t mk(bit r, bit v, int rt, bit rdrt, bit imm, bit wr, int rd,
                              bit ld, bit fl, bit es, bit ev, int em, int ef, int ec);
    vec_t t;
    t.rst = r; t.v = v; t.rt = rt; t.rdrt = rdrt; t.imm = imm; t.wr = wr; t.rd = rd;
    t.ld = ld; t.fl = fl; t.e_stall = es; t.e_valid = ev; t.e_mux = em; t.e_fwd = ef;
    t.e_cnt = ec;
    return t;
  endfunction

  task automatic chk(input string n, input int a, input int e);
    n_total++;
    if (a == e) n_pass++;
    else $display("FAIL %s: got %0d want %0d", n, a, e);
  endtask

  function automatic bit produces(ent_t e, int rt);
    return e.v && e.w && e.rd != 0 && e.rd == rt;
  endfunction

  task automatic model_eval(output bit st, output int fw);
    bit reads, h_ex, h_mem;
    reads = id_valid && id_reads_rt;
    h_ex  = reads && produces(m_ex, int'(id_rt));
    h_mem = reads && produces(m_mem, int'(id_rt));
    if (FWD) begin
      st = h_ex && m_ex.ld;
      fw = h_ex ? 1 : (h_mem ? 2 : 0);
    end else begin
      st = h_ex || h_mem;
      fw = 0;
    end
    if (rst || flush) st = 0;
  endtask

  task automatic model_clock(input bit st, input int fw);
    ent_t empty;
    empty = '{0, 0, 0, 0};
    if (rst) begin
      m_ex = empty; m_mem = empty; m_cnt = 0; m_valid = 0; m_mux = 0; m_fwd = 0;
    end else begin
      m_mem = m_ex;
      if (st || flush) begin
        m_ex = empty; m_valid = 0; m_mux = 0; m_fwd = 0;
      end else begin
        m_ex    = '{id_valid, id_wr_en, int'(id_rd), id_is_load};
        m_valid = id_valid;
        m_mux   = id_use_imm ? 2 : 0;
        m_fwd   = fw;
      end
      if (st && m_cnt != CNT_MAX) m_cnt++;
    end
  endtask

  task automatic step(input vec_t t, input bit use_tbl, input string tag);
    bit st; int fw;
    rst = t.rst; id_valid = t.v; id_rt = 5'(t.rt); id_reads_rt = t.rdrt;
    id_use_imm = t.imm; id_wr_en = t.wr; id_rd = 5'(t.rd); id_is_load = t.ld; flush = t.fl;
    #1;
    model_eval(st, fw);
    chk({tag, " stall"}, int'(stall), use_tbl ? int'(t.e_stall) : int'(st));
    @(posedge clk); #1;
    model_clock(st, fw);
    chk({tag, " ex_valid"}, int'(ex_valid), use_tbl ? int'(t.e_valid) : m_valid);
    chk({tag, " ex_mux_lines"}, int'(ex_mux_lines), use_tbl ? t.e_mux : m_mux);
    chk({tag, " ex_fwd_sel"}, int'(ex_fwd_sel), use_tbl ? t.e_fwd : m_fwd);
    chk({tag, " stall_cnt"}, int'(stall_cnt), use_tbl ? t.e_cnt : m_cnt);
  endtask

  initial begin
    m_ex = '{0, 0, 0, 0};
    m_mem = '{0, 0, 0, 0};
    //             rst v rt rdrt imm wr rd ld fl | stall valid mux fwd cnt
`ifdef OPB_HAZARD_FWD_EN
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0)); // reset
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 5, 0, 0,   0, 1, 0, 0, 0)); // addu r5
    tbl.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0, 0,   0, 1, 0, 1, 0)); // use r5 -> EX/MEM
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 7, 1, 0,   0, 1, 0, 0, 0)); // lw r7
    tbl.push_back(mk(0, 1, 7, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 1)); // load-use stall
    tbl.push_back(mk(0, 1, 7, 1, 0, 0, 0, 0, 0,   0, 1, 0, 2, 1)); // retry -> MEM/WB
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 3, 0, 0,   0, 1, 0, 0, 1)); // addu r3
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 3, 0, 0,   0, 1, 0, 0, 1)); // addu r3 again
    tbl.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0,   0, 1, 0, 1, 1)); // EX beats MEM
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0,   0, 1, 0, 0, 1)); // writer of r0
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1)); // read r0 -> RF
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 9, 1, 0,   0, 1, 0, 0, 1)); // lw r9
    tbl.push_back(mk(0, 1, 9, 1, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1)); // hazard + flush
    tbl.push_back(mk(0, 1, 9, 1, 0, 0, 0, 0, 0,   0, 1, 0, 2, 1)); // MEM kept by flush
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 2, 0, 0,   0, 1, 0, 0, 1)); // addu r2
    tbl.push_back(mk(0, 1, 2, 0, 1, 0, 0, 0, 0,   0, 1, 2, 0, 1)); // immediate B
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 8, 1, 0,   0, 1, 0, 0, 1)); // lw r8
    tbl.push_back(mk(0, 1, 8, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 2)); // stall
    tbl.push_back(mk(1, 1, 8, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0)); // reset mid-stall
    tbl.push_back(mk(0, 1, 8, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0)); // hazard discarded
`else
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0)); // reset
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 4, 0, 0,   0, 1, 0, 0, 0)); // addu r4
    tbl.push_back(mk(0, 1, 4, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 1)); // EX match stall
    tbl.push_back(mk(0, 1, 4, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 2)); // MEM match stall
    tbl.push_back(mk(0, 1, 4, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 2)); // proceeds, fwd 00
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0,   0, 1, 2, 0, 2)); // writer of r0, imm
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 2)); // read r0, no stall
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 9, 1, 0,   0, 1, 0, 0, 2)); // lw r9
    tbl.push_back(mk(0, 1, 9, 0, 1, 0, 0, 0, 0,   0, 1, 2, 0, 2)); // immediate B
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 6, 0, 0,   0, 1, 0, 0, 2)); // addu r6
    tbl.push_back(mk(0, 1, 6, 1, 0, 0, 0, 0, 1,   0, 0, 0, 0, 2)); // hazard + flush
    tbl.push_back(mk(0, 0, 6, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2)); // invalid ID
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 8, 0, 0,   0, 1, 0, 0, 2)); // addu r8
    tbl.push_back(mk(0, 1, 8, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 3)); // stall
    tbl.push_back(mk(1, 1, 8, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0)); // reset mid-stall
    tbl.push_back(mk(0, 1, 8, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0)); // hazard discarded
`endif

    foreach (tbl[i]) step(tbl[i], 1'b1, $sformatf("vec%0d", i));

    for (int i = 0; i < 400; i++) begin
      vec_t r;
      r = mk($urandom_range(0, 31) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 7),
             $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 3) != 0,
             $urandom_range(0, 7), $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
             0, 0, 0, 0, 0);
      step(r, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
